// File: rtl/day_of_week_display_if.sv
// rtl/day_of_week_display_if.sv - control and display bundle for day_of_week_display
// Signals:
//   day_tick  - single-cycle pulse, advance one day (midnight rollover)
//   set_mode  - level, 1 = user edit mode
//   inc, dec  - raw button levels, rising edge steps the day in set mode
//   load      - single-cycle pulse, load load_day
//   load_day  - day index to load (7 is rejected)
//   day       - current day index 0=Mon .. 6=Sun
//   week_wrap - one-cycle pulse after a day_tick rollover 6->0
//   leds2/1/0 - left/middle/right 7-segment digits, bit order abcdefg
// Modports: master drives the controls, slave is the day_of_week_display block.
interface day_of_week_display_if;
  logic       day_tick;
  logic       set_mode;
  logic       inc;
  logic       dec;
  logic       load;
  logic [2:0] load_day;
  logic [2:0] day;
  logic       week_wrap;
  logic [0:6] leds2;
  logic [0:6] leds1;
  logic [0:6] leds0;

  modport master (
    output day_tick, set_mode, inc, dec, load, load_day,
    input  day, week_wrap, leds2, leds1, leds0
  );

  modport slave (
    input  day_tick, set_mode, inc, dec, load, load_day,
    output day, week_wrap, leds2, leds1, leds0
  );
endinterface

// File: rtl/day_of_week_display.sv
// rtl/day_of_week_display.sv - day-of-week register with edit buttons and 3-letter 7-segment name
// Optional feature macro: DOW_BLINK_EN (digits blink while set_mode is high)
// Parameters:
//   START_DAY      - day index loaded at reset, values above 6 load 0
//   SEG_ACTIVE_LOW - 1 = segment lit when its bit is 0
//   BLINK_DIV      - clock cycles per blink half-period (DOW_BLINK_EN only)
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - day_of_week_display_if.slave (controls in, day/week_wrap/leds out)
module day_of_week_display #(
  parameter int unsigned START_DAY      = 0,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter int unsigned BLINK_DIV      = 25000000
) (
  input logic                  clk,
  input logic                  rst_n,
  day_of_week_display_if.slave bus
);

  localparam logic [2:0]  START_IDX = (START_DAY > 6) ? 3'd0 : 3'(START_DAY);
  localparam logic [20:0] SEG_MASK  = {21{SEG_ACTIVE_LOW}};

  // Active-high glyphs packed {leds2, leds1, leds0}, each digit MSB = segment a.
  // Index 7 never holds in day_q but maps to blank for safety.
  function automatic logic [20:0] glyph(input logic [2:0] d);
    logic [20:0] g;
    case (d)
      3'd0:    g = {7'b1110110, 7'b0011101, 7'b0010101}; // Mon
      3'd1:    g = {7'b0001111, 7'b0111110, 7'b1001111}; // Tue
      3'd2:    g = {7'b0011100, 7'b1001111, 7'b0111101}; // Wed
      3'd3:    g = {7'b0001111, 7'b0010111, 7'b0011100}; // Thu
      3'd4:    g = {7'b1000111, 7'b0000101, 7'b0000100}; // Fri
      3'd5:    g = {7'b1011011, 7'b1110111, 7'b0001111}; // Sat
      3'd6:    g = {7'b1011011, 7'b0111110, 7'b1110110}; // Sun
      default: g = 21'd0;
    endcase
    return g;
  endfunction

  // Button synchronisers and edge detectors
  logic       inc_s1_q, inc_s2_q, inc_prev_q;
  logic       dec_s1_q, dec_s2_q, dec_prev_q;
  // Counts clocks since reset release. The edge detectors are only trusted once
  // both synchroniser stages and the previous-level flop hold real samples, so a
  // button held through reset does not look like a fresh press on release.
  logic [1:0] warm_q;
  logic       inc_edge, dec_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_s1_q   <= 1'b0;
      inc_s2_q   <= 1'b0;
      inc_prev_q <= 1'b0;
      dec_s1_q   <= 1'b0;
      dec_s2_q   <= 1'b0;
      dec_prev_q <= 1'b0;
      warm_q     <= 2'd0;
    end else begin
      inc_s1_q   <= bus.inc;
      inc_s2_q   <= inc_s1_q;
      inc_prev_q <= inc_s2_q;
      dec_s1_q   <= bus.dec;
      dec_s2_q   <= dec_s1_q;
      dec_prev_q <= dec_s2_q;
      if (warm_q != 2'd3) begin
        warm_q <= warm_q + 2'd1;
      end
    end
  end

  assign inc_edge = (warm_q == 2'd3) && inc_s2_q && !inc_prev_q;
  assign dec_edge = (warm_q == 2'd3) && dec_s2_q && !dec_prev_q;

  // Day register and next-state selection
  logic [2:0] day_q, day_d;
  logic       wrap_q, wrap_d;

  always_comb begin
    day_d  = day_q;
    wrap_d = 1'b0;
    if (day_q == 3'd7) begin
      // Illegal state recovery, takes precedence over everything else.
      day_d = 3'd0;
    end else if (bus.load) begin
      // A load of 7 is rejected outright and still blocks lower-priority actions.
      if (bus.load_day != 3'd7) begin
        day_d = bus.load_day;
      end
    end else if (bus.set_mode) begin
      // Edges that arrive outside set mode are simply lost, never queued.
      if (inc_edge && !dec_edge) begin
        day_d = (day_q == 3'd6) ? 3'd0 : day_q + 3'd1;
      end else if (dec_edge && !inc_edge) begin
        day_d = (day_q == 3'd0) ? 3'd6 : day_q - 3'd1;
      end
    end else if (bus.day_tick) begin
      day_d  = (day_q == 3'd6) ? 3'd0 : day_q + 3'd1;
      wrap_d = (day_q == 3'd6);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_q  <= START_IDX;
      wrap_q <= 1'b0;
    end else begin
      day_q  <= day_d;
      wrap_q <= wrap_d;
    end
  end

  // Blink phase
  logic blank_now;

`ifdef DOW_BLINK_EN
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic             set_prev_q;
  logic [CNT_W-1:0] blink_cnt_q;
  logic             blink_hidden_q;
  logic             step_evt;

  // A user step is any edit that actually moves the day (one edge alone, no load).
  assign step_evt = bus.set_mode && !bus.load && (day_q != 3'd7) && (inc_edge ^ dec_edge);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_prev_q     <= 1'b0;
      blink_cnt_q    <= '0;
      blink_hidden_q <= 1'b0;
    end else begin
      set_prev_q <= bus.set_mode;
      if (!bus.set_mode) begin
        blink_cnt_q    <= '0;
        blink_hidden_q <= 1'b0;
      end else if (!set_prev_q || step_evt) begin
        // Entering edit mode or stepping restarts a full visible half-period so
        // the user always sees the value just chosen.
        blink_cnt_q    <= '0;
        blink_hidden_q <= 1'b0;
      end else if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
        blink_cnt_q    <= '0;
        blink_hidden_q <= !blink_hidden_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign blank_now = blink_hidden_q;
`else
  assign blank_now = 1'b0;

  // BLINK_DIV has no role without the blink feature; a zero value is still
  // flagged as a structural oddity by keeping this empty named block.
  if (BLINK_DIV == 0) begin : g_blink_div_zero
  end
`endif

  // Registered display, one cycle behind day_q.
  logic [20:0] leds_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds_q <= glyph(START_IDX) ^ SEG_MASK;
    end else begin
      leds_q <= (blank_now ? 21'd0 : glyph(day_q)) ^ SEG_MASK;
    end
  end

  assign bus.day       = day_q;
  assign bus.week_wrap = wrap_q;
  assign bus.leds2     = leds_q[20:14];
  assign bus.leds1     = leds_q[13:7];
  assign bus.leds0     = leds_q[6:0];

endmodule

// File: tb/tb_day_of_week_display.sv
// tb/tb_day_of_week_display.sv - randomized self-checking bench for day_of_week_display
module tb_day_of_week_display;
  localparam int unsigned START_DAY = 5;
  localparam bit          SEG_LOW   = 1'b1;
  localparam int unsigned BDIV      = 4;
  localparam logic [20:0] MASK      = {21{SEG_LOW}};

  logic clk;
  logic rst_n;
  day_of_week_display_if bus ();

  day_of_week_display #(
    .START_DAY      (START_DAY),
    .SEG_ACTIVE_LOW (SEG_LOW),
    .BLINK_DIV      (BDIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;

  // Day-name glyph table, active-high, {left, middle, right}
  logic [20:0] glyph_t [0:6];
  initial begin
    glyph_t[0] = {7'b1110110, 7'b0011101, 7'b0010101};
    glyph_t[1] = {7'b0001111, 7'b0111110, 7'b1001111};
    glyph_t[2] = {7'b0011100, 7'b1001111, 7'b0111101};
    glyph_t[3] = {7'b0001111, 7'b0010111, 7'b0011100};
    glyph_t[4] = {7'b1000111, 7'b0000101, 7'b0000100};
    glyph_t[5] = {7'b1011011, 7'b1110111, 7'b0001111};
    glyph_t[6] = {7'b1011011, 7'b0111110, 7'b1110110};
  end

  // Reference model state
  int          m_day;
  logic        m_wrap;
  logic [20:0] m_leds;
  bit          h_inc[$];
  bit          h_dec[$];
  bit          m_set_prev;
  int          m_since;

  function automatic bit model_hidden(input int since);
`ifdef DOW_BLINK_EN
    return ((since / BDIV) % 2) == 1;
`else
    return (since < 0);
`endif
  endfunction

  task automatic model_reset();
    m_day      = START_DAY;
    m_wrap     = 1'b0;
    m_leds     = glyph_t[START_DAY] ^ MASK;
    h_inc      = {};
    h_dec      = {};
    m_set_prev = 1'b0;
    m_since    = 0;
  endtask

  // One clock: advance the model by the rules using the inputs the DUT sampled.
  task automatic tick();
    bit ie, de, step;
    int n;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      h_inc.push_back(bus.inc);
      h_dec.push_back(bus.dec);
      if (h_inc.size() > 4) void'(h_inc.pop_front());
      if (h_dec.size() > 4) void'(h_dec.pop_front());
      n  = h_inc.size();
      // A press is seen two cycles late; samples from before reset do not count.
      ie = (n >= 4) && h_inc[n-3] && !h_inc[n-4];
      de = (n >= 4) && h_dec[n-3] && !h_dec[n-4];
      m_leds = (model_hidden(m_since) ? 21'd0 : glyph_t[m_day]) ^ MASK;
      m_wrap = 1'b0;
      step   = 1'b0;
      if (bus.load) begin
        if (bus.load_day <= 3'd6) m_day = int'(bus.load_day);
      end else if (bus.set_mode) begin
        if (ie && !de) begin m_day = (m_day + 1) % 7; step = 1'b1; end
        else if (de && !ie) begin m_day = (m_day + 6) % 7; step = 1'b1; end
      end else if (bus.day_tick) begin
        if (m_day == 6) m_wrap = 1'b1;
        m_day = (m_day + 1) % 7;
      end
      if (!bus.set_mode || !m_set_prev || step) m_since = 0;
      else m_since++;
      m_set_prev = bus.set_mode;
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.day_tick = 1'b0;
    bus.set_mode = 1'b0;
    bus.inc      = 1'b0;
    bus.dec      = 1'b0;
    bus.load     = 1'b0;
    bus.load_day = 3'd0;
  endtask

  task automatic do_load(input logic [2:0] d);
    bus.load = 1'b1;
    bus.load_day = d;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    checks++;
    if (bus.day !== 3'd5) begin
      errors++; $display("FAIL reset_day got=%0d exp=5", bus.day);
    end
    checks++;
    if (bus.week_wrap !== 1'b0) begin
      errors++; $display("FAIL reset_wrap got=%0b exp=0", bus.week_wrap);
    end
    checks++;
    if ({bus.leds2, bus.leds1, bus.leds0} !== {7'b0100100, 7'b0001000, 7'b1110000}) begin
      errors++; $display("FAIL reset_leds got=%b_%b_%b exp=0100100_0001000_1110000",
                         bus.leds2, bus.leds1, bus.leds0);
    end
  endtask

  task automatic test_tick_wrap();
    int wraps;
    do_load(3'd6);
    checks++;
    if (bus.day !== 3'd6) begin
      errors++; $display("FAIL wrap_load got=%0d exp=6", bus.day);
    end
    bus.day_tick = 1'b1;
    tick();
    bus.day_tick = 1'b0;
    checks++;
    if (bus.day !== 3'd0 || bus.week_wrap !== 1'b1) begin
      errors++; $display("FAIL wrap_first got day=%0d wrap=%0b exp day=0 wrap=1", bus.day, bus.week_wrap);
    end
    tick();
    checks++;
    if (bus.week_wrap !== 1'b0) begin
      errors++; $display("FAIL wrap_pulse_len got=%0b exp=0", bus.week_wrap);
    end
    checks++;
    if ({bus.leds2, bus.leds1, bus.leds0} !== {7'b0001001, 7'b1100010, 7'b1101010}) begin
      errors++; $display("FAIL wrap_mon_leds got=%b_%b_%b exp=0001001_1100010_1101010",
                         bus.leds2, bus.leds1, bus.leds0);
    end
    wraps = 0;
    for (int i = 0; i < 7; i++) begin
      bus.day_tick = 1'b1;
      tick();
      wraps += int'(bus.week_wrap);
      bus.day_tick = 1'b0;
      tick();
      wraps += int'(bus.week_wrap);
      checks++;
      if (bus.day !== 3'(m_day)) begin
        errors++; $display("FAIL wrap_walk got=%0d exp=%0d", bus.day, m_day);
      end
    end
    checks++;
    if (bus.day !== 3'd0 || wraps != 1) begin
      errors++; $display("FAIL wrap_week got day=%0d wraps=%0d exp day=0 wraps=1", bus.day, wraps);
    end
  endtask

  task automatic test_set_mode();
    bus.set_mode = 1'b1;
    do_load(3'd3);
    repeat (4) tick();
    bus.inc = 1'b1;
    repeat (50) tick();
    checks++;
    if (bus.day !== 3'd4) begin
      errors++; $display("FAIL set_inc_held got=%0d exp=4", bus.day);
    end
    bus.inc = 1'b0;
    repeat (3) tick();
    do_load(3'd0);
    bus.dec = 1'b1;
    repeat (4) tick();
    bus.dec = 1'b0;
    repeat (2) tick();
    checks++;
    if (bus.day !== 3'd6) begin
      errors++; $display("FAIL set_dec_wrap got=%0d exp=6", bus.day);
    end
    bus.inc = 1'b1;
    bus.dec = 1'b1;
    repeat (4) tick();
    bus.inc = 1'b0;
    bus.dec = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.day !== 3'd6) begin
      errors++; $display("FAIL set_both got=%0d exp=6", bus.day);
    end
    for (int i = 0; i < 3; i++) begin
      bus.day_tick = 1'b1;
      tick();
      bus.day_tick = 1'b0;
      tick();
    end
    checks++;
    if (bus.day !== 3'd6 || bus.week_wrap !== 1'b0) begin
      errors++; $display("FAIL set_tick_ignored got day=%0d wrap=%0b exp day=6 wrap=0", bus.day, bus.week_wrap);
    end
  endtask

  task automatic test_load_priority();
    bus.set_mode = 1'b1;
    repeat (3) tick();
    bus.inc = 1'b1;
    tick();
    tick();
    do_load(3'd2);
    checks++;
    if (bus.day !== 3'd2) begin
      errors++; $display("FAIL load_wins got=%0d exp=2", bus.day);
    end
    repeat (3) tick();
    checks++;
    if (bus.day !== 3'd2) begin
      errors++; $display("FAIL load_no_late_step got=%0d exp=2", bus.day);
    end
    do_load(3'd7);
    tick();
    checks++;
    if (bus.day !== 3'd2) begin
      errors++; $display("FAIL load_seven got=%0d exp=2", bus.day);
    end
    bus.inc = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_edit();
    bus.set_mode = 1'b1;
    do_load(3'd4);
    repeat (3) tick();
    bus.inc = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bus.day !== 3'd5) begin
      errors++; $display("FAIL midedit_async got=%0d exp=5", bus.day);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.day !== 3'd5 || bus.day !== 3'(m_day)) begin
        errors++; $display("FAIL midedit_no_step got=%0d exp=5", bus.day);
      end
    end
    bus.inc = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bus.day_tick = ($urandom % 4) == 0;
      bus.load     = ($urandom % 20) == 0;
      bus.load_day = 3'($urandom % 8);
      if (($urandom % 3) == 0) bus.inc = ~bus.inc;
      if (($urandom % 3) == 0) bus.dec = ~bus.dec;
      if (($urandom % 25) == 0) bus.set_mode = ~bus.set_mode;
      tick();
      checks++;
      if (bus.day !== 3'(m_day) || bus.week_wrap !== m_wrap) begin
        errors++; $display("FAIL random_day cyc=%0d got day=%0d wrap=%0b exp day=%0d wrap=%0b",
                           i, bus.day, bus.week_wrap, m_day, m_wrap);
      end
      checks++;
      if ({bus.leds2, bus.leds1, bus.leds0} !== m_leds) begin
        errors++; $display("FAIL random_leds cyc=%0d got=%h exp=%h", i,
                           {bus.leds2, bus.leds1, bus.leds0}, m_leds);
      end
    end
    idle_inputs();
    repeat (4) tick();
  endtask

`ifdef DOW_BLINK_EN
  task automatic test_blink();
    int blanks;
    idle_inputs();
    do_load(3'd1);
    repeat (3) tick();
    bus.set_mode = 1'b1;
    blanks = 0;
    for (int i = 0; i < 40; i++) begin
      bus.inc = (i >= 15 && i < 20);
      tick();
      if ({bus.leds2, bus.leds1, bus.leds0} === MASK) blanks++;
      checks++;
      if ({bus.leds2, bus.leds1, bus.leds0} !== m_leds) begin
        errors++; $display("FAIL blink_leds cyc=%0d got=%h exp=%h", i,
                           {bus.leds2, bus.leds1, bus.leds0}, m_leds);
      end
    end
    checks++;
    if (blanks == 0) begin
      errors++; $display("FAIL blink_seen got=0 blank cycles exp>0");
    end
    bus.set_mode = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({bus.leds2, bus.leds1, bus.leds0} !== (glyph_t[m_day] ^ MASK)) begin
        errors++; $display("FAIL blink_steady cyc=%0d got=%h exp=%h", i,
                           {bus.leds2, bus.leds1, bus.leds0}, glyph_t[m_day] ^ MASK);
      end
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_tick_wrap();
    idle_inputs();
    test_set_mode();
    idle_inputs();
    repeat (3) tick();
    test_load_priority();
    idle_inputs();
    test_reset_mid_edit();
    idle_inputs();
    test_random();
`ifdef DOW_BLINK_EN
    test_blink();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/day_of_week_display.md
Name: day_of_week_display

Overview:
Sequential successor to the combinational day-name decoder. It holds the current day of week (0=Mon … 6=Sun) and advances it on a daily tick from the clock/calendar chain. It supports user edit (set mode with inc/dec buttons) and direct load. It drives three 7-segment digits with the 3-letter day name and sits between the time-of-day counter and the display board.

Parameters:
START_DAY, 0, day index loaded at reset (0..6; values >6 treated as 0)
SEG_ACTIVE_LOW, 1, 1 = segment on when bit is 0 (board default); 0 = active-high
BLINK_DIV, 25000000, clock cycles per blink half-period (used only with DOW_BLINK_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
day_tick  in  1  single-cycle pulse, advance one day (midnight rollover)
set_mode  in  1  level; 1 = user edit mode
inc  in  1  button level, raw; rising edge = +1 day in set mode
dec  in  1  button level, raw; rising edge = −1 day in set mode
load  in  1  single-cycle pulse, load load_day
load_day  in  3  day index to load
day  out  3  current day index, registered
week_wrap  out  1  one-cycle pulse when day goes 6→0 via day_tick
leds2  out  [0:6]  leftmost letter, bit order abcdefg
leds1  out  [0:6]  middle letter
leds0  out  [0:6]  rightmost letter

Behaviour:
- Reset (async, rst_n=0): day=START_DAY; week_wrap=0; edge-detect registers=0; blink counter=0, blink phase=visible; leds show START_DAY glyphs.
- inc/dec pass through a 2-flop synchroniser, then an edge detector. Action occurs on the cycle the synchronised level goes 0→1; held buttons give exactly one step.
- Update priority per cycle:
  1. load: if load_day ≤ 6, day ← load_day; if load_day = 7, ignore the load and no other action happens that cycle.
  2. set_mode=1: an inc edge alone gives day ← (day+1) mod 7; a dec edge alone gives day ← (day+6) mod 7; simultaneous inc+dec edges give no change. day_tick is ignored in set mode.
  3. set_mode=0: day_tick gives day ← (day+1) mod 7; inc/dec edges are ignored and discarded (not queued).
- Wrap: 6→0 on +1; 0→6 on −1.
- week_wrap = 1 only for the cycle after a day_tick advance from 6→0. It is never asserted for inc, dec or load.
- Display is registered from day, giving 1-cycle latency day→leds. Output = glyph XOR {7{SEG_ACTIVE_LOW}}.
- Glyphs are active-high abcdefg, listed leds2/leds1/leds0:
  - Mon: 1110110/0011101/0010101
  - Tue: 0001111/0111110/1001111
  - Wed: 0011100/1001111/0111101
  - Thu: 0001111/0010111/0011100
  - Fri: 1000111/0000101/0000100
  - Sat: 1011011/1110111/0001111
  - Sun: 1011011/0111110/1110110
  - Blank: 0000000
- day never holds 7. Illegal-state recovery: if day=7 is detected, force day to 0 next cycle.

Optional Feature:
DOW_BLINK_EN
- Defined: while set_mode=1, a counter toggles blink phase every BLINK_DIV cycles; all three digits show Blank in the hidden phase. Entering set_mode (0→1) or any inc/dec step resets the counter and forces the visible phase. With set_mode=0, digits are always visible and the counter is held at 0.
- Undefined: no counter logic; glyphs are always shown; BLINK_DIV is unused.

Test Plan:
- Reset with START_DAY=5, SEG_ACTIVE_LOW=1 → day=5, leds2=0100100, leds1=0001000, leds0=1110000 immediately after rst_n rises.
- From day=6, pulse day_tick (set_mode=0) → day=0 next cycle, week_wrap high exactly 1 cycle, then Mon glyphs one cycle later; 7 further ticks return to 0 with exactly one more week_wrap.
- set_mode=1, hold inc high 50 cycles → exactly one increment (3→4); dec edge at day=0 → 6; inc+dec edges in the same cycle → no change; day_tick pulses → ignored.
- load with load_day=2 while an inc edge is present in set mode → day=2 (load wins); load_day=7 → day unchanged.
- Assert rst_n low mid-edit (day=4, inc pending in synchroniser) → day=START_DAY asynchronously; no spurious step after release even with inc still held high.
- With DOW_BLINK_EN, BLINK_DIV=4, set_mode=1 → digits alternate glyph/blank every 4 cycles; an inc step restarts the visible phase; set_mode=0 → steady glyphs.
